wimax_block_scheduler: RTL

//  Sequences 96-bit blocks from the SPI deserializer into the downstream WiMAX PHY chain
//  (randomizer -> FEC -> interleaver -> modulator). The deserializer raises a one-cycle

---
 rtl/wimax_block_scheduler.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/wimax_block_scheduler.sv
// -----------------------------------------------------------------------------
// wimax_block_scheduler
//
// Buffers 96-bit blocks from the SPI deserializer in a small FIFO and issues
// them to the WiMAX PHY chain on a valid/ready handshake. Blocks are grouped
// into frames of BLOCKS_PER_FRAME. The first and last blocks of each frame are
// marked. After every frame there is an idle gap of GAP_CYCLES so downstream
// stages can reload their seeds. The deserializer cannot be stalled. A block
// that arrives while the FIFO is full is dropped, and a sticky overflow flag
// records the loss.
//
// Ports
//   clk             in   rising-edge clock
//   reset           in   synchronous, active-high reset
//   i_enable        in   allow frame transmission (sampled at frame boundaries)
//   i_blk_valid_in  in   one-cycle pulse: i_blk_data_in holds a complete block
//   i_blk_data_in   in   block from the deserializer
//   i_out_ready     in   downstream accepts o_out_data this cycle
//   o_out_valid     out  o_out_data is valid
//   o_out_data      out  FIFO head block
//   o_frame_start   out  valid block is block 0 of a frame
//   o_out_last      out  valid block is the last block of a frame
//   o_overflow      out  sticky: a block was dropped on a full FIFO
//   o_busy          out  not idle, or blocks still buffered
//   o_frame_cnt     out  frames completed, wraps modulo 2^16
// -----------------------------------------------------------------------------
module wimax_block_scheduler #(
    parameter int BLOCK_WIDTH      = 96,
    parameter int BLOCKS_PER_FRAME = 4,
    parameter int FIFO_DEPTH       = 2,
    parameter int GAP_CYCLES       = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_enable,
    input  logic                   i_blk_valid_in,
    input  logic [BLOCK_WIDTH-1:0] i_blk_data_in,
    input  logic                   i_out_ready,
    output logic                   o_out_valid,
    output logic [BLOCK_WIDTH-1:0] o_out_data,
    output logic                   o_frame_start,
    output logic                   o_out_last,
    output logic                   o_overflow,
    output logic                   o_busy,
    output logic [15:0]            o_frame_cnt
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int IW = (BLOCKS_PER_FRAME > 1) ? $clog2(BLOCKS_PER_FRAME) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [IW-1:0] LAST_IDX = IW'(BLOCKS_PER_FRAME - 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    // FIFO storage and pointers; the depth is a power of two, so pointers wrap naturally
    logic [BLOCK_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]          r_wr_ptr;
    logic [AW-1:0]          r_rd_ptr;
    logic [AW:0]            r_count;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [GW-1:0]          r_gap_cnt;
    logic [GW-1:0]          w_gap_nxt;
    logic [IW-1:0]          r_blk_idx;
    logic [15:0]            r_frame_cnt;
    logic                   r_overflow;

    logic                   w_empty;
    logic                   w_full;
    logic                   w_pop;
    logic                   w_push;
    logic                   w_last_pop;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == FULL_CNT);
    assign w_pop      = o_out_valid && i_out_ready;
    // A full FIFO still takes a block when the head leaves in the same cycle
    assign w_push     = i_blk_valid_in && (!w_full || w_pop);
    assign w_last_pop = w_pop && (r_blk_idx == LAST_IDX);

    assign o_out_valid   = (r_state == S_SEND) && !w_empty;
    assign o_out_data    = r_mem[r_rd_ptr];
    assign o_frame_start = o_out_valid && (r_blk_idx == '0);
    assign o_out_last    = o_out_valid && (r_blk_idx == LAST_IDX);
    assign o_overflow    = r_overflow;
    assign o_busy        = (r_state != S_IDLE) || !w_empty;
    assign o_frame_cnt   = r_frame_cnt;

    // Next-state logic. enable is only looked at on the IDLE->SEND decision and
    // at the end of a frame, so a frame that has started always completes.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
        w_state_nxt = r_state;
        w_gap_nxt   = r_gap_cnt;
        case (r_state)
            S_IDLE: begin
                if (i_enable && !w_empty) begin
                    w_state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                if (w_last_pop) begin
                    if (GAP_CYCLES > 0) begin
                        w_state_nxt = S_GAP;
                        w_gap_nxt   = GAP_LOAD;
                    end else begin
                        w_state_nxt = i_enable ? S_SEND : S_IDLE;
                    end
                end
            end
            S_GAP: begin
                if (r_gap_cnt == '0) begin
                    w_state_nxt = i_enable ? S_SEND : S_IDLE;
                end else begin
                    w_gap_nxt = r_gap_cnt - GW'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            r_state     <= S_IDLE;
            r_gap_cnt   <= '0;
            r_blk_idx   <= '0;
            r_frame_cnt <= '0;
            r_overflow  <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            // NOTE: the storage is cleared on reset because o_out_data reads it directly and must be 0 after reset.
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_state   <= w_state_nxt;
            r_gap_cnt <= w_gap_nxt;

            if (w_push) begin
                r_mem[r_wr_ptr] <= i_blk_data_in;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end

            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + 1'b1;
                r_blk_idx <= w_last_pop ? '0 : r_blk_idx + 1'b1;
            end

            if (w_last_pop) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            if (i_blk_valid_in && !w_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule
